onehot_qual_reg: RTL and testbench

//  Downstream stage of the 3-to-8 decoder (latch_c) output bus.
//  - Synchronises and qualifies the decoder's 8-bit one-hot word.
//  - Accepts a word only after it has been legal and stable for STABLE_CNT samples; then holds it as a registered output.
//  - Also provides a 3-bit re-encode, a change pulse, a saturating change counter and an illegal-word flag.

---
 rtl/onehot_qual_reg_pkg.sv | 14 +
 rtl/onehot_qual_reg_enc8.sv | 24 ++
 rtl/onehot_qual_reg.sv | 160 ++++++++++++++++
 tb/tb_onehot_qual_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/onehot_qual_reg_pkg.sv
// rtl/onehot_qual_reg_pkg.sv - shared widths and FSM state encoding for onehot_qual_reg
// Contents: DEC_W (one-hot bus width), ENC_W (encoded index width), state_e (WAIT/QUAL/LOCK).
package onehot_qual_reg_pkg;

  localparam int DEC_W = 8;
  localparam int ENC_W = 3;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_QUAL = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_qual_reg_enc8.sv
// rtl/onehot_qual_reg_enc8.sv - combinational 8-bit one-hot to 3-bit index encoder with legality flag
// Ports:
//   onehot_i  in   DEC_W  word to encode
//   idx_o     out  ENC_W  index of the set bit (highest set bit if multi-hot, 0 if none)
//   legal_o   out  1      exactly one bit set
module onehot_qual_reg_enc8
  import onehot_qual_reg_pkg::*;
(
  input  logic [DEC_W-1:0] onehot_i,
  output logic [ENC_W-1:0] idx_o,
  output logic             legal_o
);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < DEC_W; i++) begin
      if (onehot_i[i]) idx_o = ENC_W'(i);
    end
  end

  // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
  assign legal_o = (onehot_i != '0) && ((onehot_i & (onehot_i - DEC_W'(1))) == '0);

endmodule

// File: rtl/onehot_qual_reg.sv
// rtl/onehot_qual_reg.sv - synchronise, qualify and hold the decoder's one-hot word
// Ports:
//   sys_clk     in   1      clock, all logic on rising edge
//   sys_rst     in   1      synchronous active-high reset
//   dec_in      in   DEC_W  one-hot word, asynchronous to sys_clk
//   onehot_out  out  DEC_W  last locked word
//   code_out    out  ENC_W  binary index of onehot_out
//   valid       out  1      a word has locked since reset
//   chg_pulse   out  1      one cycle when a lock changes the held word
//   chg_cnt     out  CNT_W  saturating count of chg_pulse events
//   err         out  1      one cycle per illegal sample after warm-up
module onehot_qual_reg
  import onehot_qual_reg_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [DEC_W-1:0] dec_in,
  output logic [DEC_W-1:0] onehot_out,
  output logic [ENC_W-1:0] code_out,
  output logic             valid,
  output logic             chg_pulse,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             err
);

  localparam int QW = $clog2(STABLE_CNT + 1);

  logic [DEC_W-1:0] s1_q, s2_q;
  state_e           state_q, state_d;
  logic [DEC_W-1:0] cand_q, cand_d;
  logic [QW-1:0]    cnt_q, cnt_d;
  logic [DEC_W-1:0] onehot_q, onehot_d;
  logic [ENC_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;
  logic             err_q, err_d;
  logic [1:0]       warm_q, warm_d;
  logic             lock;
  logic [ENC_W-1:0] s2_idx;
  logic             s2_legal;

  onehot_qual_reg_enc8 u_enc (
    .onehot_i (s2_q),
    .idx_o    (s2_idx),
    .legal_o  (s2_legal)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    onehot_d  = onehot_q;
    code_d    = code_q;
    valid_d   = valid_q;
    pulse_d   = 1'b0;
    chg_cnt_d = chg_cnt_q;
    lock      = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (s2_legal) begin
          cand_d  = s2_q;
          cnt_d   = QW'(1);
          state_d = ST_QUAL;
        end
      end
      ST_QUAL: begin
        // cand is always legal, so a match implies a legal sample.
        if (s2_q == cand_q) begin
          if (cnt_q == QW'(STABLE_CNT - 1)) begin
            lock    = 1'b1;
            cnt_d   = '0;
            state_d = ST_LOCK;
          end else begin
            cnt_d = cnt_q + QW'(1);
          end
        end else if (s2_legal) begin
          cand_d = s2_q;
          cnt_d  = QW'(1);
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_LOCK: begin
        if (s2_q != onehot_q) begin
          if (s2_legal) begin
            cand_d  = s2_q;
            cnt_d   = QW'(1);
            state_d = ST_QUAL;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
    endcase

    if (lock) begin
      onehot_d = cand_q;
      // On the lock edge s2 equals cand, so the s2 encoder gives cand's index.
      code_d   = s2_idx;
      valid_d  = 1'b1;
      pulse_d  = (cand_q != onehot_q) || !valid_q;
      if (pulse_d && (chg_cnt_q != '1)) chg_cnt_d = chg_cnt_q + CNT_W'(1);
    end
  end

  // Two edges after reset release s2 still carries the reset zeros; hide them from err.
  always_comb begin
    warm_d = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    err_d  = !s2_legal && (warm_q == 2'd2);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      state_q   <= ST_WAIT;
      cand_q    <= '0;
      cnt_q     <= '0;
      onehot_q  <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      pulse_q   <= 1'b0;
      chg_cnt_q <= '0;
      err_q     <= 1'b0;
      warm_q    <= '0;
    end else begin
      s1_q      <= dec_in;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      onehot_q  <= onehot_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pulse_q   <= pulse_d;
      chg_cnt_q <= chg_cnt_d;
      err_q     <= err_d;
      warm_q    <= warm_d;
    end
  end

  assign onehot_out = onehot_q;
  assign code_out   = code_q;
  assign valid      = valid_q;
  assign chg_pulse  = pulse_q;
  assign chg_cnt    = chg_cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_onehot_qual_reg.sv
// tb/tb_onehot_qual_reg.sv - randomized self-checking bench for onehot_qual_reg against a run-length model
module tb_onehot_qual_reg;

  localparam int STABLE_CNT = 4;

  logic       clk;
  logic       rst;
  logic [7:0] dec_in;

  logic [7:0] onehot_out, onehot_s;
  logic [2:0] code_out, code_s;
  logic       valid, valid_s;
  logic       chg_pulse, pulse_s;
  logic [7:0] chg_cnt;
  logic [1:0] cnt_s;
  logic       err, err_s;

  onehot_qual_reg #(.STABLE_CNT(STABLE_CNT), .CNT_W(8)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .dec_in     (dec_in),
    .onehot_out (onehot_out),
    .code_out   (code_out),
    .valid      (valid),
    .chg_pulse  (chg_pulse),
    .chg_cnt    (chg_cnt),
    .err        (err)
  );

  onehot_qual_reg #(.STABLE_CNT(STABLE_CNT), .CNT_W(2)) dut_sat (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .dec_in     (dec_in),
    .onehot_out (onehot_s),
    .code_out   (code_s),
    .valid      (valid_s),
    .chg_pulse  (pulse_s),
    .chg_cnt    (cnt_s),
    .err        (err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a 2-sample delay line, then lock whenever the run of identical
  // legal samples reaches exactly STABLE_CNT.
  logic [7:0] m_dly[2];
  int         m_run;
  logic [7:0] m_runval;
  logic [7:0] m_held;
  logic       m_valid, m_pulse, m_err;
  int         m_chg;
  int         m_since;

  function automatic int idx_of(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_edge(input logic [7:0] v, input logic r);
    logic [7:0] smp;
    logic       lgl;
    if (r) begin
      m_dly[0] = '0; m_dly[1] = '0;
      m_run = 0; m_runval = '0; m_held = '0;
      m_valid = 1'b0; m_pulse = 1'b0; m_err = 1'b0;
      m_chg = 0; m_since = 0;
    end else begin
      smp = m_dly[1];
      lgl = ($countones(smp) == 1);
      m_err = !lgl && (m_since >= 2);
      if (m_since < 2) m_since++;
      m_pulse = 1'b0;
      if (!lgl) m_run = 0;
      else if (m_run > 0 && smp == m_runval) m_run++;
      else begin m_run = 1; m_runval = smp; end
      if (lgl && m_run == STABLE_CNT) begin
        m_pulse = !m_valid || (smp != m_held);
        if (m_pulse) m_chg++;
        m_held  = smp;
        m_valid = 1'b1;
      end
      m_dly[1] = m_dly[0];
      m_dly[0] = v;
    end
  endtask

  task automatic compare_all();
    int c8 = (m_chg > 255) ? 255 : m_chg;
    int c2 = (m_chg > 3) ? 3 : m_chg;
    check("onehot",   32'(onehot_out), 32'(m_held));
    check("code",     32'(code_out),   32'(idx_of(m_held)));
    check("valid",    32'(valid),      32'(m_valid));
    check("pulse",    32'(chg_pulse),  32'(m_pulse));
    check("chg_cnt",  32'(chg_cnt),    32'(c8));
    check("err",      32'(err),        32'(m_err));
    check("s_onehot", 32'(onehot_s),   32'(m_held));
    check("s_code",   32'(code_s),     32'(idx_of(m_held)));
    check("s_valid",  32'(valid_s),    32'(m_valid));
    check("s_pulse",  32'(pulse_s),    32'(m_pulse));
    check("s_cnt",    32'(cnt_s),      32'(c2));
    check("s_err",    32'(err_s),      32'(m_err));
  endtask

  task automatic step(input logic [7:0] v, input logic r);
    @(negedge clk);
    dec_in = v;
    rst    = r;
    @(posedge clk);
    model_edge(v, r);
    #1;
    compare_all();
  endtask

  logic [7:0] cur;
  int         hold;
  int         rr;

  initial begin
    dec_in = '0;
    rst    = 1'b1;

    // Lock: first capture edge is step 1, outputs update on step 6.
    step(8'h04, 1'b1);
    check("rst_onehot", 32'(onehot_out), 32'h0);
    check("rst_valid",  32'(valid),      32'h0);
    check("rst_cnt",    32'(chg_cnt),    32'h0);
    repeat (5) step(8'h04, 1'b0);
    check("prelock_valid", 32'(valid), 32'h0);
    step(8'h04, 1'b0);
    check("lock_onehot", 32'(onehot_out), 32'h04);
    check("lock_code",   32'(code_out),   32'h2);
    check("lock_pulse",  32'(chg_pulse),  32'h1);
    check("lock_cnt",    32'(chg_cnt),    32'h1);
    step(8'h04, 1'b0);
    check("pulse_once",  32'(chg_pulse),  32'h0);

    // Glitch shorter than STABLE_CNT samples.
    repeat (2) step(8'h10, 1'b0);
    repeat (8) step(8'h04, 1'b0);
    check("glitch_onehot", 32'(onehot_out), 32'h04);
    check("glitch_cnt",    32'(chg_cnt),    32'h1);

    // One illegal sample: err two edges later for one cycle, then a silent relock.
    step(8'h0C, 1'b0);
    step(8'h04, 1'b0);
    check("ill_err_early", 32'(err), 32'h0);
    step(8'h04, 1'b0);
    check("ill_err",       32'(err), 32'h1);
    step(8'h04, 1'b0);
    check("ill_err_once",  32'(err), 32'h0);
    repeat (6) step(8'h04, 1'b0);
    check("ill_onehot", 32'(onehot_out), 32'h04);
    check("ill_cnt",    32'(chg_cnt),    32'h1);

    // Change to 8'h80.
    repeat (6) step(8'h80, 1'b0);
    check("chg_code",   32'(code_out),   32'h7);
    check("chg_onehot", 32'(onehot_out), 32'h80);
    check("chg_cnt",    32'(chg_cnt),    32'h2);

    // Reset while qualifying.
    repeat (2) step(8'h02, 1'b0);
    step(8'h02, 1'b1);
    check("mid_rst_onehot", 32'(onehot_out), 32'h0);
    check("mid_rst_valid",  32'(valid),      32'h0);
    check("mid_rst_cnt",    32'(chg_cnt),    32'h0);
    repeat (5) step(8'h02, 1'b0);
    check("mid_rst_nolock", 32'(valid), 32'h0);
    step(8'h02, 1'b0);
    check("mid_rst_lock",   32'(valid), 32'h1);

    // Saturation of the 2-bit counter after alternating changes.
    for (int k = 0; k < 5; k++) repeat (7) step((k % 2 == 0) ? 8'h01 : 8'h02, 1'b0);
    check("sat_cnt",  32'(cnt_s),   32'h3);
    check("full_cnt", 32'(chg_cnt), 32'h6);

    // Soak: legal one-hot values with random hold lengths.
    for (int k = 0; k < 300; k++) begin
      cur  = 8'(1 << $urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      repeat (hold) step(cur, 1'b0);
    end

    // Mixed: occasional resets and arbitrary (often illegal) bytes.
    cur = 8'h01;
    for (int k = 0; k < 800; k++) begin
      rr = $urandom_range(0, 99);
      if (rr < 3) step(cur, 1'b1);
      else if (rr < 25) step(8'($urandom), 1'b0);
      else begin
        if ($urandom_range(0, 9) < 3) cur = 8'(1 << $urandom_range(0, 7));
        step(cur, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
